// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and channel slicing helper for mux_scan
package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int MAX_W    = 64;
    localparam int MAX_BITS = 1024;
    localparam int AW       = $clog2(MAX_BITS);

    // Channel k of a packed vector of n channels, each w bits; zero when k >= n.
    function automatic logic [MAX_W-1:0] chan_slice(
        input logic [MAX_BITS-1:0] vec,
        input int                  w,
        input int                  n,
        input int                  k
    );
        logic [MAX_W-1:0] r;
        r = '0;
        if (k < n) begin
            for (int i = 0; i < MAX_W; i++) begin
                if (i < w) r[i] = vec[AW'(k * w + i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_scan_ctr.sv
// rtl/mux_scan_ctr.sv - round-robin pointer, dwell counter and mode history
module mux_scan_ctr
    import mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int DWELL = 2,
    parameter int SW    = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          mode,
    input  logic          stall,
    input  logic          cap,
    output logic [SW-1:0] ptr,
    output logic          tick
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] LAST = DW'(DWELL - 1);

    logic [DW-1:0] dcnt;
    logic          mode_q;
    logic          mode_rise;
    logic          scan_cap;

    assign mode_rise = (mode == MODE_SCAN) & (mode_q == MODE_MANUAL);
    assign scan_cap  = cap & (mode == MODE_SCAN) & ~stall;
    // The scan-entry cycle only rewinds the pointer; it never captures.
    assign tick      = (dcnt == LAST) & ~mode_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= '0;
            dcnt   <= '0;
            mode_q <= MODE_MANUAL;
        end else begin
            mode_q <= mode;
            if (mode_rise) begin
                ptr  <= '0;
                dcnt <= '0;
            end else if (scan_cap) begin
                dcnt <= '0;
                ptr  <= (ptr == SW'(N - 1)) ? '0 : ptr + 1'b1;
            end else if (en && mode == MODE_SCAN && dcnt < LAST) begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan.sv
// rtl/mux_scan.sv - N-channel manual/scan multiplexer with registered valid/ready output
module mux_scan
    import mux_pkg::*;
#(
    parameter int W     = 8,
    parameter int N     = 4,
    parameter int SW    = $clog2(N),
    parameter int DWELL = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] din,
    input  logic [SW-1:0]  sel,
    input  logic           mode,
    input  logic           en,
    output logic [W-1:0]   dout,
    output logic [SW-1:0]  ch,
    output logic           valid,
    input  logic           ready
);

    logic [SW-1:0]       ptr;
    logic                tick;
    logic                stall;
    logic                cap;
    logic [SW-1:0]       idx;
    logic [W-1:0]        data;
    logic [MAX_BITS-1:0] din_ext;

    assign stall   = valid & ~ready;
    assign cap     = en & ~stall & ((mode == MODE_MANUAL) | tick);
    assign idx     = (mode == MODE_SCAN) ? ptr : sel;
    assign din_ext = MAX_BITS'(din);
    assign data    = W'(chan_slice(din_ext, W, N, int'(idx)));

    mux_scan_ctr #(
        .N     (N),
        .DWELL (DWELL),
        .SW    (SW)
    ) u_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .mode  (mode),
        .stall (stall),
        .cap   (cap),
        .ptr   (ptr),
        .tick  (tick)
    );

    // A held sample is only replaced by a capture, which a stall blocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout  <= '0;
            ch    <= '0;
            valid <= 1'b0;
        end else if (cap) begin
            dout  <= data;
            ch    <= idx;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_scan.sv
// tb/tb_mux_scan.sv - self-checking bench for mux_scan with a behavioural reference model
module tb_mux_scan;

    localparam int W     = 8;
    localparam int N     = 4;
    localparam int SW    = 2;
    localparam int DWELL = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N*W-1:0] din = 32'h4433_2211;
    logic [SW-1:0]  sel = '0;
    logic           mode = 1'b0;
    logic           en = 1'b0;
    logic           ready = 1'b0;
    logic [W-1:0]   dout;
    logic [SW-1:0]  ch;
    logic           valid;

    int n_checks = 0;
    int n_fail = 0;
    bit chk_on = 0;

    mux_scan #(.W(W), .N(N), .SW(SW), .DWELL(DWELL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (din),
        .sel   (sel),
        .mode  (mode),
        .en    (en),
        .dout  (dout),
        .ch    (ch),
        .valid (valid),
        .ready (ready)
    );

    always #5 clk = ~clk;

    // Reference model: what the consumer should see, tracked as plain integers.
    int  m_dout, m_ch, m_ptr, m_elapsed;
    bit  m_valid, m_prev_mode;

    always @(posedge clk or negedge rst_n) begin
        bit entering, can_take, due, take;
        int pick;
        if (!rst_n) begin
            m_dout = 0; m_ch = 0; m_valid = 0;
            m_ptr = 0; m_elapsed = 0; m_prev_mode = 0;
        end else begin
            entering = mode && !m_prev_mode;
            can_take = en && (!m_valid || ready);
            due      = !mode || (!entering && m_elapsed >= DWELL - 1);
            take     = can_take && due;
            pick     = mode ? m_ptr : int'(sel);
            if (take) begin
                m_dout  = (pick < N) ? int'((din >> (pick * W)) & 32'hFF) : 0;
                m_ch    = pick;
                m_valid = 1;
            end else if (m_valid && ready) begin
                m_valid = 0;
            end
            if (entering) begin
                m_ptr = 0;
                m_elapsed = 0;
            end else if (take && mode) begin
                m_ptr = (m_ptr + 1) % N;
                m_elapsed = 0;
            end else if (en && mode && m_elapsed < DWELL - 1) begin
                m_elapsed++;
            end
            m_prev_mode = mode;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_valid", 32'(valid), 32'(m_valid));
            chk("model_ch", 32'(ch), 32'(m_ch));
            chk("model_dout", 32'(dout), 32'(m_dout));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [7:0] d, input logic [1:0] c, input logic v);
        chk({name, "_dout"}, 32'(dout), 32'(d));
        chk({name, "_ch"}, 32'(ch), 32'(c));
        chk({name, "_valid"}, 32'(valid), 32'(v));
    endtask

    initial begin
        step(1);
        chk_on = 1;
        step(1);
        expect_out("reset", 8'h00, 2'd0, 1'b0);
        rst_n = 1'b1;

        // manual stepping
        en = 1'b1; ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] exp_d;
            exp_d = 8'h11 * 8'(i + 1);
            sel = SW'(i);
            step(1);
            expect_out("manual", exp_d, 2'(i), 1'b1);
        end

        // asynchronous reset while a sample is pending
        #3 rst_n = 1'b0;
        #1 chk("async_reset_valid", 32'(valid), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // scan: entry cycle with en low, then enable
        en = 1'b0; mode = 1'b1;
        step(1);
        en = 1'b1;
        step(1);
        chk("scan_first_wait", 32'(valid), 32'd0);
        step(1);
        expect_out("scan_first", 8'h11, 2'd0, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            logic [7:0] exp_d;
            exp_d = 8'h11 * 8'((i % N) + 1);
            step(2);
            expect_out("scan_seq", exp_d, 2'(i % N), 1'b1);
        end

        // stall holding 22, with din disturbed
        ready = 1'b0;
        din = 32'h4433_AA11;
        for (int i = 0; i < 5; i++) begin
            step(1);
            expect_out("stall_hold", 8'h22, 2'd1, 1'b1);
        end
        ready = 1'b1;
        din = 32'h4433_2211;
        step(1);
        expect_out("stall_release", 8'h33, 2'd2, 1'b1);

        // bring ptr to 2, then leave and re-enter scan
        step(6);
        expect_out("ptr_to_2", 8'h22, 2'd1, 1'b1);
        mode = 1'b0; en = 1'b0;
        step(1);
        chk("manual_idle_valid", 32'(valid), 32'd0);
        mode = 1'b1; en = 1'b1;
        step(1);
        chk("reentry_no_cap", 32'(valid), 32'd0);
        step(1);
        chk("reentry_wait", 32'(valid), 32'd0);
        step(1);
        expect_out("reentry_first", 8'h11, 2'd0, 1'b1);

        // handshake corner: accept with en low
        mode = 1'b0; sel = 2'd2;
        step(1);
        expect_out("manual_back", 8'h33, 2'd2, 1'b1);
        en = 1'b0;
        step(1);
        expect_out("accept_drop", 8'h33, 2'd2, 1'b0);

        // randomized traffic checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            en    = ($urandom % 4) != 0;
            ready = ($urandom % 3) != 0;
            sel   = SW'($urandom % N);
            if ($urandom % 20 == 0) mode = ~mode;
            if ($urandom % 4 == 0) din = $urandom;
            step(1);
        end

        chk_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_scan.md
Name: mux_scan

Overview:
- Next-generation multiplexer: N input channels, each W bits wide, with a registered output and a valid/ready output handshake.
- Two modes:
  - Manual: the channel is picked by sel.
  - Scan: an internal round-robin pointer steps through all channels, holding each for DWELL cycles.
- Sits between parallel data sources and a single consumer. Used for time-multiplexed monitoring and sampling of several buses.

Parameters:
- W, 8: data width per channel, in bits.
- N, 4: number of channels (N >= 2).
- SW, $clog2(N): width of sel and ch.
- DWELL, 2: cycles per channel in scan mode (DWELL >= 1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  N*W  packed inputs; channel k occupies bits [k*W +: W].
- sel  in  SW  channel select, manual mode only.
- mode  in  1  0 = manual, 1 = scan.
- en  in  1  capture enable.
- dout  out  W  registered selected data.
- ch  out  SW  index of the channel held in dout.
- valid  out  1  dout/ch hold an unconsumed sample.
- ready  in  1  consumer accepts the sample when valid & ready.

Behaviour:
- Reset: rst_n low asynchronously clears dout = 0, ch = 0, valid = 0, scan pointer ptr = 0, dwell counter dcnt = 0, mode_q = 0. Reset mid-operation discards any pending sample.
- Capture condition: cap = en & (~valid | ready) & (mode == 0 | dcnt == DWELL-1).
- Manual mode, on cap:
  - dout <= din[sel], ch <= sel, valid <= 1.
  - Latency is 1 cycle from sel/din to dout.
  - If sel >= N: dout <= 0, ch <= sel.
- Scan mode:
  - dcnt increments each cycle while en = 1 and dcnt < DWELL-1, then saturates.
  - On cap: dout <= din[ptr], ch <= ptr, valid <= 1, dcnt <= 0, ptr <= (ptr == N-1) ? 0 : ptr + 1.
  - The first sample appears DWELL cycles after en rises; the sequence is 0, 1, ..., N-1, 0, ...
- Handshake:
  - valid & ready with no cap in the same cycle: valid <= 0.
  - valid & ready with cap in the same cycle: new sample loaded, valid stays 1 (back-to-back, no bubble).
  - valid & ~ready (stall): dout, ch and valid are frozen; ptr does not advance; dcnt saturates at DWELL-1. The held sample is never overwritten or dropped.
- en = 0: no capture, dcnt holds. A pending sample remains valid until accepted.
- Mode change:
  - mode_q registers mode.
  - On a 0->1 transition (mode & ~mode_q), ptr <= 0 and dcnt <= 0 that cycle, and no scan capture occurs that cycle.
  - On a 1->0 transition, manual capture is allowed in the same cycle.
  - A sample pending across a mode change is preserved until accepted.
- DWELL = 1: dcnt is always 0, so scan captures every unstalled cycle.
- din is sampled only at cap; changes to din while stalled have no effect on dout.

Decomposition:
- Package mux_pkg:
  - Constants MODE_MANUAL = 1'b0, MODE_SCAN = 1'b1.
  - Function that slices channel k from a packed N*W vector, returning 0 when k >= N.
- Sub-module mux_scan_ctr:
  - Contains ptr, dcnt and mode_q.
  - Inputs: clk, rst_n, en, mode, stall, cap.
  - Outputs: ptr, tick (dcnt == DWELL-1).
- Top level: the output register, valid logic and data select.

Test Plan (W = 8, N = 4, DWELL = 2; din = {8'h44, 8'h33, 8'h22, 8'h11}):
- Reset then idle: rst_n low for 2 cycles, en = 0 -> dout = 0, ch = 0, valid = 0. Assert rst_n low asynchronously mid-cycle while valid = 1 -> valid drops immediately.
- Manual mode, ready = 1, en = 1, sel stepping 0, 1, 2, 3 one per cycle -> next cycle dout = 11, 22, 33, 44; ch tracks sel; valid stays 1 throughout.
- Scan mode, ready = 1, en rises -> first sample dout = 11 with ch = 0 at cycle 2, then 22 / 33 / 44 / 11 every 2 cycles (wrap 3 -> 0).
- Stall in scan: drop ready for 5 cycles while holding 22 -> dout = 22 and ch = 1 stable and valid = 1; raise ready -> next sample is 33 one cycle later; no channel skipped.
- Mode 0 -> 1 switch with ptr = 2: switch cycle has no scan capture; next scan samples begin at ch = 0.
- Handshake corner: manual mode, valid = 1, ready = 1, en = 0 -> valid drops next cycle. Change din while stalled -> dout unchanged.
